// File: rtl/spi_word_transceiver_pkg.sv
// Shared SPI framing constants for the word transceiver, the command decoder and the host driver.
// Mode 0 (CPOL=0, CPHA=0), MSB first, 64-bit words by default.
package spi_word_transceiver_pkg;

  localparam int unsigned WORD_BITS_DEFAULT = 64;

  localparam bit SPI_CPOL      = 1'b0;
  localparam bit SPI_CPHA      = 1'b0;
  localparam bit SPI_MSB_FIRST = 1'b1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_word_transceiver_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous input.
// A history flop on the synchronized value yields single-cycle rise/fall strobes.
module sync_edge_detect #(
  parameter int unsigned STAGES     = 2,
  parameter logic        IDLE_VALUE = 1'b0
) (
  input  logic CLK,
  input  logic resetn,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic              hist_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      chain_q <= {STAGES{IDLE_VALUE}};
      hist_q  <= IDLE_VALUE;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din};
      hist_q  <= chain_q[STAGES-1];
    end
  end

  assign sync = chain_q[STAGES-1];
  assign rise = sync & ~hist_q;
  assign fall = ~sync & hist_q;

endmodule

// File: rtl/spi_word_transceiver.sv
// SPI mode-0 slave, oversampled in the CLK domain: assembles COPI into words and
// shifts a response word out on CIPO, one word per WORD_BITS SCK cycles.
module spi_word_transceiver
  import spi_word_transceiver_pkg::*;
#(
  parameter int unsigned WORD_BITS   = WORD_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic                 SCK,
  input  logic                 CS,
  input  logic                 COPI,
  output logic                 CIPO,
  input  logic [WORD_BITS-1:0] word_send_data,
  output logic [WORD_BITS-1:0] word_data_received,
  output logic                 word_received,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(WORD_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic copi_sync;
  logic copi_rise_unused, copi_fall_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_VALUE(1'b0)) u_sck_sync (
    .CLK    (CLK),
    .resetn (resetn),
    .din    (SCK),
    .sync   (sck_sync),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_VALUE(1'b1)) u_cs_sync (
    .CLK    (CLK),
    .resetn (resetn),
    .din    (CS),
    .sync   (cs_sync),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE_VALUE(1'b0)) u_copi_sync (
    .CLK    (CLK),
    .resetn (resetn),
    .din    (COPI),
    .sync   (copi_sync),
    .rise   (copi_rise_unused),
    .fall   (copi_fall_unused)
  );

  logic [0:0]           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WORD_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_BITS-1:0] rx_word_q, rx_word_d;
  logic                 word_received_q, word_received_d;
  logic                 frame_error_q, frame_error_d;
  logic                 busy_q;
  logic                 unused_sck_level;

  assign unused_sck_level = sck_sync;

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    rx_shift_d      = rx_shift_q;
    tx_shift_d      = tx_shift_q;
    rx_word_d       = rx_word_q;
    word_received_d = 1'b0;
    frame_error_d   = 1'b0;

    if (cs_fall) begin
      // Frame start loads the first response word; a coincident SCK fall is not a shift.
      state_d    = ST_ACTIVE;
      bit_cnt_d  = '0;
      tx_shift_d = word_send_data;
    end else if (state_q == ST_ACTIVE) begin
      if (cs_rise) begin
        // End of frame takes priority over any coincident SCK edge.
        state_d       = ST_IDLE;
        bit_cnt_d     = '0;
        rx_shift_d    = '0;
        frame_error_d = (bit_cnt_q != '0);
      end else if (sck_rise) begin
        rx_shift_d = {rx_shift_q[WORD_BITS-2:0], copi_sync};
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          rx_word_d       = {rx_shift_q[WORD_BITS-2:0], copi_sync};
          word_received_d = 1'b1;
        end
      end else if (sck_fall) begin
        // First fall after a completed word reloads the next response.
        tx_shift_d = (bit_cnt_q != '0) ? {tx_shift_q[WORD_BITS-2:0], 1'b0} : word_send_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      rx_shift_q      <= '0;
      tx_shift_q      <= '0;
      rx_word_q       <= '0;
      word_received_q <= 1'b0;
      frame_error_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      rx_shift_q      <= rx_shift_d;
      tx_shift_q      <= tx_shift_d;
      rx_word_q       <= rx_word_d;
      word_received_q <= word_received_d;
      frame_error_q   <= frame_error_d;
      busy_q          <= ~cs_sync;
    end
  end

  assign CIPO               = (state_q == ST_ACTIVE) & tx_shift_q[WORD_BITS-1];
  assign word_data_received = rx_word_q;
  assign word_received      = word_received_q;
  assign frame_error        = frame_error_q;
  assign busy               = busy_q;

endmodule

// File: doc/spi_word_transceiver.md
Name: spi_word_transceiver

Overview:
- Upstream SPI front end for the command state machine. Deserializes COPI into 64-bit words and serializes a 64-bit response on CIPO.
- SPI mode 0, MSB first, oversampled in the system clock domain (SCK, CS and COPI are asynchronous inputs).
- Emits a `word_received` pulse per completed word. The command decoder edge-detects this pulse before using `word_data_received`.

Parameters:
- WORD_BITS, 64, bits per word; must be a power of two, at least 8.
- SYNC_STAGES, 2, synchronizer depth for SCK/CS/COPI; valid values 2 or 3.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- SCK  input  1  SPI clock from host; asynchronous.
- CS  input  1  SPI chip select, active-low; asynchronous.
- COPI  input  1  host-to-device data; asynchronous.
- CIPO  output  1  device-to-host data.
- word_send_data  input  WORD_BITS  response word; sampled at each TX load point.
- word_data_received  output  WORD_BITS  last complete word; held until the next word completes.
- word_received  output  1  one-CLK pulse when `word_data_received` updates.
- frame_error  output  1  one-CLK pulse when CS deasserts with a partial word.
- busy  output  1  high while the synchronized CS is low.

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - all synchronizer flops at idle: SCK=0, CS=1, COPI=0;
  - bit_cnt=0, rx_shift=0, tx_shift=0;
  - `word_data_received`=0, `word_received`=0, `frame_error`=0, `busy`=0, CIPO=0.
- Synchronization: SCK, CS and COPI each pass through SYNC_STAGES flops, plus one history flop on SCK and CS for edge detection.
  - sck_rise = sync 0->1; sck_fall = sync 1->0; cs_fall and cs_rise likewise.
  - Input-to-action latency: SYNC_STAGES+1 CLK.
  - Timing requirement: SCK high and low times must each be at least SYNC_STAGES+4 CLK cycles (≥6 CLK at default, i.e. SCK ≤ CLK/12).
- State machine:
  - IDLE (CS high): SCK edges are ignored; CIPO=0.
  - IDLE -> ACTIVE on cs_fall: bit_cnt<=0; tx_shift<=word_send_data; CIPO shows word_send_data[WORD_BITS-1] from the next cycle.
  - ACTIVE, on sck_rise: rx_shift<={rx_shift[WORD_BITS-2:0], COPI_sync}; bit_cnt<=bit_cnt+1, wrapping modulo WORD_BITS.
  - ACTIVE, sck_rise with bit_cnt==WORD_BITS-1 (word complete):
    - `word_data_received` <= assembled word, with the final bit in bit 0 and the first bit in bit 63, so the header byte (first on the wire) lands in [63:56];
    - `word_received` pulses high for exactly 1 CLK in the following cycle;
    - bit_cnt wraps to 0.
  - ACTIVE, on sck_fall:
    - bit_cnt!=0: tx_shift<={tx_shift[WORD_BITS-2:0],1'b0}.
    - bit_cnt==0 (first fall after a completed word): tx_shift<=word_send_data (TX load point). The consumer has ≥SYNC_STAGES+3 CLK after the `word_received` pulse to update `word_send_data`.
  - CIPO = tx_shift[WORD_BITS-1] while ACTIVE.
  - ACTIVE -> IDLE on cs_rise:
    - bit_cnt!=0: `frame_error` pulses 1 CLK, partial rx_shift is discarded, `word_data_received` is unchanged, no `word_received` pulse.
    - bit_cnt==0: clean end, no pulse.
    - Either way bit_cnt<=0.
- Simultaneous events:
  - cs_rise in the same cycle as sck_rise: cs_rise wins; the edge is not counted.
  - cs_fall in the same cycle as sck_fall: the TX load from cs_fall applies; no shift.
- Multiple words per CS frame are supported back-to-back. There is no limit on words per frame.
- Reset mid-word: all state returns to reset values immediately; no pulses are generated.
- `busy` = CS_sync low, registered, so it lags CS by SYNC_STAGES+1 CLK.

Decomposition:
- Shared package/defines: WORD_BITS default (64) and SPI mode constant (mode 0, MSB first), so they match the command decoder and the host driver.
- One natural sub-module: `sync_edge_detect` (SYNC_STAGES-deep synchronizer producing sync, rise and fall). Instantiated three times, for SCK, CS and COPI; COPI uses the sync output only.

Test Plan:
1. Reset, then CS low, 64 SCK cycles sending 0x0100_0000_0000_0002, CS high -> one `word_received` pulse; `word_data_received`=0x0100000000000002; `frame_error`=0.
2. `word_send_data`=0xDEAD_BEEF_0000_0001 before cs_fall -> host samples CIPO bits equal to 0xDEADBEEF00000001, MSB first, over 64 SCK rises.
3. One CS frame with 3 words (0x11.., 0x22.., 0x33..); bench updates `word_send_data` 2 CLK after each pulse -> three pulses with correct data; the word returned in slot n+1 equals the value written after word n.
4. CS high after 17 bits -> one `frame_error` pulse; `word_data_received` keeps its previous value. Next full word is received correctly with bit_cnt starting from 0.
5. SCK toggling with CS high -> no pulses; CIPO=0; bit_cnt stays 0.
6. resetn low at bit 40, then release and send a full word -> all outputs at reset values during reset; the next word decodes correctly with no spurious `word_received` or `frame_error`.
